// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hold/load/flush sequencer with stall and flush counters
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memread_ex,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  rs1_used_id,
    input  logic                  rs2_used_id,
    input  logic                  branch_taken_ex,
    input  logic                  mdu_start_ex,
    input  logic                  mdu_done,
    input  logic                  dmem_req_mem,
    input  logic                  dmem_ready,
    input  logic                  imem_ready,
    output logic                  pcwrite,
    output logic                  ifidwrite,
    output logic                  ifflush,
    output logic                  idexwrite,
    output logic                  idexflush,
    output logic                  exmemwrite,
    output logic                  exmemflush,
    output logic                  memwbflush,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef enum logic [1:0] {RUN, MDU_WAIT, MEM_WAIT} state_t;

    state_t           state_q, state_d;
    logic             ret_mdu_q, ret_mdu_d;
    logic             done_pend_q, done_pend_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic new_dmem_miss;
    logic dmem_stall;
    logic mdu_busy;
    logic load_use;
    logic redirect_win;

    assign new_dmem_miss = dmem_req_mem & ~dmem_ready;
    assign dmem_stall    = (state_q == MEM_WAIT) | new_dmem_miss;
    assign mdu_busy      = ((state_q == RUN) & mdu_start_ex & ~mdu_done) |
                           ((state_q == MDU_WAIT) & ~mdu_done & ~done_pend_q);
    assign load_use      = memread_ex & (rd_ex != '0) &
                           ((rs1_used_id & (rs1_id == rd_ex)) | (rs2_used_id & (rs2_id == rd_ex)));
    assign redirect_win  = rst_n & ~dmem_stall & ~mdu_busy & branch_taken_ex;

    // Enables act in the same cycle; reset forces every enable low without waiting for a clock.
    always_comb begin
        pcwrite    = 1'b1;
        ifidwrite  = 1'b1;
        ifflush    = 1'b0;
        idexwrite  = 1'b1;
        idexflush  = 1'b0;
        exmemwrite = 1'b1;
        exmemflush = 1'b0;
        memwbflush = 1'b0;
        if (!rst_n) begin
            pcwrite    = 1'b0;
            ifidwrite  = 1'b0;
            idexwrite  = 1'b0;
            exmemwrite = 1'b0;
        end else if (dmem_stall) begin
            pcwrite    = 1'b0;
            ifidwrite  = 1'b0;
            idexwrite  = 1'b0;
            exmemwrite = 1'b0;
            memwbflush = 1'b1;
        end else if (mdu_busy) begin
            pcwrite    = 1'b0;
            ifidwrite  = 1'b0;
            idexwrite  = 1'b0;
            exmemflush = 1'b1;
        end else if (branch_taken_ex) begin
            ifflush    = 1'b1;
            idexflush  = 1'b1;
        end else if (load_use) begin
            pcwrite    = 1'b0;
            ifidwrite  = 1'b0;
            idexflush  = 1'b1;
        end else if (!imem_ready) begin
            pcwrite    = 1'b0;
            ifflush    = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ret_mdu_d   = ret_mdu_q;
        done_pend_d = done_pend_q;
        case (state_q)
            RUN: begin
                done_pend_d = 1'b0;
                if (new_dmem_miss) begin
                    state_d   = MEM_WAIT;
                    ret_mdu_d = 1'b0;
                end else if (mdu_start_ex && !mdu_done) begin
                    state_d = MDU_WAIT;
                end
            end
            MDU_WAIT: begin
                if (new_dmem_miss) begin
                    state_d     = MEM_WAIT;
                    ret_mdu_d   = 1'b1;
                    done_pend_d = done_pend_q | mdu_done;
                end else if (mdu_done || done_pend_q) begin
                    state_d     = RUN;
                    done_pend_d = 1'b0;
                end
            end
            MEM_WAIT: begin
                done_pend_d = done_pend_q | mdu_done;
                if (dmem_ready) begin
                    state_d = ret_mdu_q ? MDU_WAIT : RUN;
                    if (!ret_mdu_q) begin
                        done_pend_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = RUN;
                ret_mdu_d   = 1'b0;
                done_pend_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pcwrite && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (redirect_win && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            ret_mdu_q   <= 1'b0;
            done_pend_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_mdu_q   <= ret_mdu_d;
            done_pend_q <= done_pend_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
